// File: rtl/cache_dados_refill_ctrl.sv
// ---------------------------------------------------------------------------
// cache_dados_refill_ctrl
//   Miss/refill sequencer for the 16-line x 32-byte data cache. A read miss
//   latches the block-aligned address and issues one block read to memory.
//   The eight returned words are assembled into a line buffer, and the line,
//   tag and index are then written into the cache with a one-cycle strobe.
//
//   Optional feature macro: CACHE_STATS_EN
//     defined   -> adds saturating refill_count[15:0] and stall_cycles[31:0]
//     undefined -> no statistics ports or counters; refill behaviour is identical
//
//   All outputs are registered. The reset is synchronous and active-high.
// ---------------------------------------------------------------------------
module cache_dados_refill_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int INDEX_BITS     = 4,
  parameter int OFFSET_BITS    = 5,
  parameter int WORDS_PER_LINE = 8,
  localparam int TAG_W         = ADDR_W - INDEX_BITS - OFFSET_BITS,
  localparam int LINE_W        = 32 * WORDS_PER_LINE
) (
  input  logic                  clock,
  input  logic                  reset,
  // request side (data cache)
  input  logic                  miss,
  input  logic [ADDR_W-1:0]     miss_addr,
  output logic                  busy,
  // memory port
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_ack,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  // line write into the cache
  output logic                  fill_we,
  output logic [INDEX_BITS-1:0] fill_index,
  output logic [TAG_W-1:0]      fill_tag,
  output logic [LINE_W-1:0]     fill_data
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]           refill_count,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int CNT_W = $clog2(WORDS_PER_LINE);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_FILL  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  state_e                state_q,      state_d;
  logic [ADDR_W-1:0]     addr_q,       addr_d;
  logic [CNT_W-1:0]      word_cnt_q,   word_cnt_d;
  logic [31:0]           buf_q [WORDS_PER_LINE];
  logic [31:0]           buf_d [WORDS_PER_LINE];
  logic                  busy_q,       busy_d;
  logic                  mem_req_q,    mem_req_d;
  logic [ADDR_W-1:0]     mem_addr_q,   mem_addr_d;
  logic                  fill_we_q,    fill_we_d;
  logic [INDEX_BITS-1:0] fill_index_q, fill_index_d;
  logic [TAG_W-1:0]      fill_tag_q,   fill_tag_d;
  logic [LINE_W-1:0]     fill_data_q,  fill_data_d;

  // Block-aligned form of the incoming miss address.
  logic [ADDR_W-1:0] block_addr;
  assign block_addr = {miss_addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

  // The byte offset of the miss never matters once the block address is formed.
  logic unused_offset;
  assign unused_offset = ^miss_addr[OFFSET_BITS-1:0];

  // Next-state and next-output logic for the refill sequencer.
  always_comb begin
    // NOTE: every _d gets a hold/default value first, so no path leaves a
    // signal unassigned and no latch can be inferred.
    state_d      = state_q;
    addr_d       = addr_q;
    word_cnt_d   = word_cnt_q;
    buf_d        = buf_q;
    busy_d       = busy_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    fill_we_d    = 1'b0;
    fill_index_d = fill_index_q;
    fill_tag_d   = fill_tag_q;
    fill_data_d  = fill_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (miss) begin
          addr_d     = block_addr;
          word_cnt_d = '0;
          mem_req_d  = 1'b1;
          mem_addr_d = block_addr;
          busy_d     = 1'b1;
          state_d    = S_REQ;
        end
      end

      S_REQ: begin
        // Request and address stay put until the memory accepts them.
        mem_addr_d = addr_q;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_FILL;
        end
      end

      S_FILL: begin
        // A cycle without rvalid is a bubble: nothing moves.
        if (mem_rvalid) begin
          buf_d[word_cnt_q] = mem_rdata;
          if (word_cnt_q == LAST_WORD) begin
            // Last word: the strobe and the complete line go out together,
            // so the final word is taken straight from buf_d.
            fill_we_d    = 1'b1;
            fill_index_d = addr_q[OFFSET_BITS +: INDEX_BITS];
            fill_tag_d   = addr_q[ADDR_W-1 -: TAG_W];
            for (int k = 0; k < WORDS_PER_LINE; k++) begin
              fill_data_d[32*k +: 32] = buf_d[k];
            end
            state_d = S_WRITE;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end

      S_WRITE: begin
        // The line is written during this cycle; return to IDLE unconditionally.
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State and registered outputs, with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the edge regardless of order.
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      word_cnt_q   <= '0;
      busy_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      fill_we_q    <= 1'b0;
      fill_index_q <= '0;
      fill_tag_q   <= '0;
      fill_data_q  <= '0;
      // NOTE: the line buffer is reset on purpose: an aborted refill must not
      // leave a partial line behind, even though it costs reset fan-out.
      for (int k = 0; k < WORDS_PER_LINE; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      word_cnt_q   <= word_cnt_d;
      busy_q       <= busy_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      fill_we_q    <= fill_we_d;
      fill_index_q <= fill_index_d;
      fill_tag_q   <= fill_tag_d;
      fill_data_q  <= fill_data_d;
      for (int k = 0; k < WORDS_PER_LINE; k++) begin
        buf_q[k] <= buf_d[k];
      end
    end
  end

  assign busy       = busy_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign fill_we    = fill_we_q;
  assign fill_index = fill_index_q;
  assign fill_tag   = fill_tag_q;
  assign fill_data  = fill_data_q;

`ifdef CACHE_STATS_EN
  logic [15:0] refill_count_q, refill_count_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Saturating statistics: one refill per WRITE cycle, one stall per busy cycle.
  always_comb begin
    refill_count_d = refill_count_q;
    stall_cycles_d = stall_cycles_q;
    if (state_q == S_WRITE && refill_count_q != '1) begin
      refill_count_d = refill_count_q + 16'd1;
    end
    if (busy_q && stall_cycles_q != '1) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  // Statistics registers, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      refill_count_q <= '0;
      stall_cycles_q <= '0;
    end else begin
      refill_count_q <= refill_count_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign refill_count = refill_count_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule
